// File: rtl/gray_pkg.sv
// ============================================================================
// gray_pkg : shared width limits, step decode type and Gray conversion helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package gray_pkg;

  localparam int unsigned GRAY_WIDTH_MIN = 2;
  localparam int unsigned GRAY_WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } gray_op_e;

  // Bits at or above 'width' are forced to zero in both helpers.
  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
    input logic [GRAY_WIDTH_MAX-1:0] bin_v,
    input int                        width
  );
    logic [GRAY_WIDTH_MAX-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(GRAY_WIDTH_MAX); i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return (bin_v ^ (bin_v >> 1)) & mask;
  endfunction

  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(
    input logic [GRAY_WIDTH_MAX-1:0] gray_v,
    input int                        width
  );
    logic [GRAY_WIDTH_MAX-1:0] res;
    logic                      acc;
    res = '0;
    acc = 1'b0;
    for (int i = int'(GRAY_WIDTH_MAX) - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray_v[i];
        res[i] = acc;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
// ============================================================================
// gray2bin : combinational Gray-to-binary converter (prefix XOR from the MSB)
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray2bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each bit reduces its own slice so no bit depends on another output bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/gray_counter.sv
// ============================================================================
// gray_counter : up/down binary-state counter with Gray output, load,
//                sticky overflow/underflow flags and a wrap pulse
// Revision     : 1.0
// ============================================================================
`default_nettype none

module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             ov_clr_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] binary_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             wrap_o
);

  if ((WIDTH < GRAY_WIDTH_MIN) || (WIDTH > GRAY_WIDTH_MAX)) begin : g_width_check
    $error("gray_counter: WIDTH %0d outside %0d..%0d",
           WIDTH, GRAY_WIDTH_MIN, GRAY_WIDTH_MAX);
  end

  localparam logic [WIDTH-1:0] C_MAX_COUNT = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] w_load_bin;
  gray_op_e         w_op;

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .gray_i (load_val_i),
    .bin_o  (w_load_bin)
  );

  always_comb begin
    w_op = OP_HOLD;
    if (load_i) begin
      w_op = OP_LOAD;
    end else if (en_i) begin
      w_op = dir_i ? OP_UP : OP_DOWN;
    end
  end

  // Clear is applied before any set so a same-cycle crossing keeps its flag.
  always_comb begin
    bin_d  = bin_q;
    ovf_d  = ovf_q & ~ov_clr_i;
    unf_d  = unf_q & ~ov_clr_i;
    wrap_d = 1'b0;
    case (w_op)
      OP_LOAD: begin
        bin_d = w_load_bin;
      end
      OP_UP: begin
        if (bin_q == C_MAX_COUNT) begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            bin_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      OP_DOWN: begin
        if (bin_q == '0) begin
          unf_d = 1'b1;
          if (!SATURATE) begin
            bin_d  = C_MAX_COUNT;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray_o      = bin_q ^ (bin_q >> 1);
  assign binary_o    = bin_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign wrap_o      = wrap_q;

endmodule

`default_nettype wire
